// File: rtl/i2c_byte_shifter.sv
// I2C master data-phase shifter: takes one byte over valid/ready, shifts it onto SDA
// MSB first with generated SCL, samples the slave ACK and pulses done.
module i2c_byte_shifter #(
  parameter int HALF_PER = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic       scl_out,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       nack
);

  localparam int CW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

  typedef enum logic [2:0] {IDLE, LOW, HIGH, ACK_LOW, ACK_HIGH, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          rdy_q, rdy_d;
  logic          phase_end;
  logic          accept;

  assign phase_end = (cnt_q == CW'(HALF_PER - 1));
  assign accept    = in_valid & rdy_q & enable & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ack_d   = ack_q;
    nack_d  = nack_q;

    if (!enable) begin
      // Abort: release the bus entirely, keep the last ACK result
      state_d = IDLE;
      cnt_d   = '0;
      scl_d   = 1'b1;
      sda_d   = 1'b1;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (accept) begin
            state_d = LOW;
            sh_d    = in_data;
            bit_d   = 3'd7;
            scl_d   = 1'b0;
            sda_d   = in_data[7];
            oe_d    = ~in_data[7];
            busy_d  = 1'b1;
            ack_d   = 1'b0;
            nack_d  = 1'b0;
          end
        end
        LOW: begin
          if (phase_end) begin
            state_d = HIGH;
            cnt_d   = '0;
            scl_d   = 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            cnt_d = '0;
            scl_d = 1'b0;
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) begin
              state_d = ACK_LOW;
              sda_d   = 1'b1;
              oe_d    = 1'b0;
            end else begin
              // SDA only moves together with the SCL falling edge
              state_d = LOW;
              sh_d    = {sh_q[6:0], 1'b0};
              sda_d   = sh_q[6];
              oe_d    = ~sh_q[6];
            end
          end
        end
        ACK_LOW: begin
          if (phase_end) begin
            state_d = ACK_HIGH;
            cnt_d   = '0;
            scl_d   = 1'b1;
          end
        end
        ACK_HIGH: begin
          if (phase_end) begin
            state_d = DONE;
            cnt_d   = '0;
            scl_d   = 1'b0;
            done_d  = 1'b1;
            ack_d   = ~sda_in;
            nack_d  = sda_in;
          end
        end
        DONE: begin
          // SCL stays low in IDLE; the stop generator takes over the bus
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    rdy_d = enable & (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd7;
      sh_q    <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready = rdy_q;
  assign sda_out  = sda_q;
  assign sda_oe   = oe_q;
  assign scl_out  = scl_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_ok   = ack_q;
  assign nack     = nack_q;

endmodule
